// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared constants, FSM state encoding and op codes for the memory responder.
package mem_responder_pkg;
  localparam int WORD_BITS = 32;
  localparam int DEF_WAIT_CYCLES = 2;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESPOND = 2'd2} state_t;
  typedef enum logic [1:0] {OP_NONE = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2, OP_ERR = 2'd3} op_t;
  // Misaligned or simultaneous read+write both become OP_ERR at acceptance
  function automatic op_t decode_op(logic rd, logic wr, logic [1:0] lsb);
    return !(rd || wr) ? OP_NONE : ((rd && wr) || lsb != 2'b00) ? OP_ERR : rd ? OP_READ : OP_WRITE;
  endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: word-indexed storage with synchronous write and registered read.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] idx,
  input  logic [WORD_BITS-1:0] wdata,
  output logic [WORD_BITS-1:0] rdata
);
  logic [WORD_BITS-1:0] mem [2**ADDR_BITS];
  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= '0;
    else if (re) rdata <= mem[idx];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: multicycle memory slave with fixed wait-state latency and error reporting.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int ADDR_BITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        busy,
  output logic        mem_err
);
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  state_t state, state_nx;
  op_t op, op_cur;
  logic [3:0] cnt, cnt_nx;
  logic [ADDR_BITS-1:0] idx_q, idx_cur;
  logic [31:0] data_q, data_cur;
  logic accept, enter, unused_addr;
  assign unused_addr = ^addr[31:ADDR_BITS+2];
  // With zero wait cycles the access happens on the acceptance edge, so use live inputs in IDLE
  always_comb begin
    accept   = state == S_IDLE && (mem_read || mem_write);
    op_cur   = state == S_IDLE ? decode_op(mem_read, mem_write, addr[1:0]) : op;
    idx_cur  = state == S_IDLE ? addr[ADDR_BITS+1:2] : idx_q;
    data_cur = state == S_IDLE ? write_data : data_q;
    state_nx = state;
    cnt_nx   = cnt;
    if (accept) begin
      state_nx = WAIT_CYCLES > 0 ? S_WAIT : S_RESPOND;
      cnt_nx   = CNT_LOAD;
    end else if (state == S_WAIT) begin
      state_nx = cnt == 4'd0 ? S_RESPOND : S_WAIT;
      cnt_nx   = cnt == 4'd0 ? cnt : cnt - 4'd1;
    end else if (state == S_RESPOND) begin
      state_nx = S_IDLE;
    end
    enter = rst && state_nx == S_RESPOND && state != S_RESPOND;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op     <= OP_NONE;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        op     <= op_cur;
        idx_q  <= idx_cur;
        data_q <= data_cur;
      end
    end
  assign mem_ready = state == S_RESPOND;
  assign mem_err   = mem_ready && op == OP_ERR;
  assign busy      = state != S_IDLE;
  mem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (enter && op_cur == OP_WRITE),
    .re   (enter && op_cur == OP_READ),
    .idx  (idx_cur),
    .wdata(data_cur),
    .rdata(read_data)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of two responders, WAIT_CYCLES=2 (slot 0) and WAIT_CYCLES=0 (slot 1).
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_read[2], mem_write[2], ready[2], busy[2], err[2];
  logic [31:0] addr[2], wdata[2], rdata[2];
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  mem_responder #(.WAIT_CYCLES(2), .ADDR_BITS(8)) dut2 (
    .clk(clk), .rst(rst), .mem_read(mem_read[0]), .mem_write(mem_write[0]), .addr(addr[0]),
    .write_data(wdata[0]), .read_data(rdata[0]), .mem_ready(ready[0]), .busy(busy[0]), .mem_err(err[0])
  );
  mem_responder #(.WAIT_CYCLES(0), .ADDR_BITS(8)) dut0 (
    .clk(clk), .rst(rst), .mem_read(mem_read[1]), .mem_write(mem_write[1]), .addr(addr[1]),
    .write_data(wdata[1]), .read_data(rdata[1]), .mem_ready(ready[1]), .busy(busy[1]), .mem_err(err[1])
  );

  // One controller transaction; inputs are scrambled while busy to show only latched values matter
  task automatic xact(input int s, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic e, output logic [31:0] q, output logic b);
    @(negedge clk);
    mem_read[s] = rd; mem_write[s] = wr; addr[s] = a; wdata[s] = d;
    @(posedge clk);
    @(negedge clk);
    b = busy[s];
    addr[s] = a ^ 32'h44; wdata[s] = ~d;
    lat = 1;
    while (!ready[s] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = err[s]; q = rdata[s];
    mem_read[s] = 1'b0; mem_write[s] = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      vectors++; if (ready[s] !== 1'b0) begin miscompares++; $display("FAIL reset_ready[%0d] got %b want 0", s, ready[s]); end
      vectors++; if (busy[s] !== 1'b0) begin miscompares++; $display("FAIL reset_busy[%0d] got %b want 0", s, busy[s]); end
      vectors++; if (err[s] !== 1'b0) begin miscompares++; $display("FAIL reset_err[%0d] got %b want 0", s, err[s]); end
      vectors++; if (rdata[s] !== 32'h0) begin miscompares++; $display("FAIL reset_rdata[%0d] got %h want 0", s, rdata[s]); end
    end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_write_read;
    int lat; logic e, b; logic [31:0] q;
    xact(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, e, q, b);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL wr_latency got %0d want 3", lat); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL wr_err got %b want 0", e); end
    vectors++; if (b !== 1'b1) begin miscompares++; $display("FAIL wr_busy got %b want 1", b); end
    xact(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, e, q, b);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL rd_latency got %0d want 3", lat); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL rd_err got %b want 0", e); end
    vectors++; if (q !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data got %h want deadbeef", q); end
  endtask

  task automatic test_misaligned;
    int lat; logic e, b; logic [31:0] q;
    xact(0, 1'b0, 1'b1, 32'h400, 32'hCAFEF00D, lat, e, q, b);
    xact(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, e, q, b);
    xact(0, 1'b0, 1'b1, 32'h402, 32'h12345678, lat, e, q, b);
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL mis_wr_err got %b want 1", e); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL mis_wr_latency got %0d want 3", lat); end
    vectors++; if (q !== 32'hDEADBEEF) begin miscompares++; $display("FAIL mis_wr_rdata got %h want deadbeef", q); end
    xact(0, 1'b1, 1'b0, 32'h401, 32'h0, lat, e, q, b);
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL mis_rd_err got %b want 1", e); end
    vectors++; if (q !== 32'hDEADBEEF) begin miscompares++; $display("FAIL mis_rd_rdata got %h want deadbeef", q); end
    xact(0, 1'b1, 1'b0, 32'h400, 32'h0, lat, e, q, b);
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL mis_readback_err got %b want 0", e); end
    vectors++; if (q !== 32'hCAFEF00D) begin miscompares++; $display("FAIL mis_readback got %h want cafef00d", q); end
  endtask

  task automatic test_both_strobes;
    int lat; logic e, b; logic [31:0] q;
    xact(0, 1'b0, 1'b1, 32'h20, 32'h0BADC0DE, lat, e, q, b);
    xact(0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, lat, e, q, b);
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL both_err got %b want 1", e); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL both_latency got %0d want 3", lat); end
    xact(0, 1'b1, 1'b0, 32'h20, 32'h0, lat, e, q, b);
    vectors++; if (q !== 32'h0BADC0DE) begin miscompares++; $display("FAIL both_readback got %h want 0badc0de", q); end
  endtask

  task automatic test_wrap;
    int lat; logic e, b; logic [31:0] q;
    xact(0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, lat, e, q, b);
    xact(0, 1'b1, 1'b0, 32'h0, 32'h0, lat, e, q, b);
    vectors++; if (q !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL wrap_0 got %h want a5a5a5a5", q); end
    xact(0, 1'b0, 1'b1, 32'h1000_0014, 32'h00000077, lat, e, q, b);
    xact(0, 1'b1, 1'b0, 32'h14, 32'h0, lat, e, q, b);
    vectors++; if (q !== 32'h00000077) begin miscompares++; $display("FAIL wrap_14 got %h want 00000077", q); end
  endtask

  task automatic test_reset_in_wait;
    int lat; logic e, b; logic [31:0] q;
    xact(0, 1'b0, 1'b1, 32'h8, 32'h11111111, lat, e, q, b);
    @(negedge clk);
    mem_write[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'h55;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vectors++; if (ready[0] !== 1'b0) begin miscompares++; $display("FAIL rstw_ready got %b want 0", ready[0]); end
    vectors++; if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL rstw_busy got %b want 0", busy[0]); end
    vectors++; if (err[0] !== 1'b0) begin miscompares++; $display("FAIL rstw_err got %b want 0", err[0]); end
    vectors++; if (rdata[0] !== 32'h0) begin miscompares++; $display("FAIL rstw_rdata got %h want 0", rdata[0]); end
    @(negedge clk);
    mem_write[0] = 1'b0;
    rst = 1'b1;
    xact(0, 1'b1, 1'b0, 32'h8, 32'h0, lat, e, q, b);
    vectors++; if (q !== 32'h11111111) begin miscompares++; $display("FAIL rstw_word got %h want 11111111", q); end
  endtask

  task automatic test_back_to_back;
    int lat; logic e, b; logic [31:0] q;
    xact(1, 1'b0, 1'b1, 32'h0, 32'h01010101, lat, e, q, b);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL w0_latency got %0d want 1", lat); end
    xact(1, 1'b0, 1'b1, 32'h4, 32'h02020202, lat, e, q, b);
    @(negedge clk);
    mem_read[1] = 1'b1; addr[1] = 32'h0;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (ready[1] !== 1'b1) begin miscompares++; $display("FAIL b2b_ready1 got %b want 1", ready[1]); end
    vectors++; if (rdata[1] !== 32'h01010101) begin miscompares++; $display("FAIL b2b_data1 got %h want 01010101", rdata[1]); end
    addr[1] = 32'h4;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (ready[1] !== 1'b0) begin miscompares++; $display("FAIL b2b_gap_ready got %b want 0", ready[1]); end
    vectors++; if (busy[1] !== 1'b0) begin miscompares++; $display("FAIL b2b_gap_busy got %b want 0", busy[1]); end
    @(posedge clk);
    @(negedge clk);
    vectors++; if (ready[1] !== 1'b1) begin miscompares++; $display("FAIL b2b_ready2 got %b want 1", ready[1]); end
    vectors++; if (rdata[1] !== 32'h02020202) begin miscompares++; $display("FAIL b2b_data2 got %h want 02020202", rdata[1]); end
    mem_read[1] = 1'b0;
    @(negedge clk);
    vectors++; if (busy[1] !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got %b want 0", busy[1]); end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      mem_read[s] = 1'b0; mem_write[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
    end
    test_reset;
    test_write_read;
    test_misaligned;
    test_both_strobes;
    test_wrap;
    test_reset_in_wait;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: idle cycles inserted between request acceptance and response (legal 0..15).
REQ-002 Parameter ADDR_BITS, default 8: word-index width, giving 2^ADDR_BITS words of 32 bits.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 mem_read  input  1  read strobe from the multicycle controller, held until mem_ready.
REQ-006 mem_write  input  1  write strobe from the multicycle controller, held until mem_ready.
REQ-007 addr  input  32  byte address from the I_or_D mux.
REQ-008 write_data  input  32  store data.
REQ-009 read_data  output  32  load or instruction word.
REQ-010 mem_ready  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high while a request is in flight (WAIT or RESPOND).
REQ-012 mem_err  output  1  error qualifier, valid only with mem_ready.

Function
REQ-013 FSM states: IDLE, WAIT, RESPOND; 2-bit encoding.
REQ-014 IDLE: if mem_read or mem_write is high at a rising edge, the request is accepted; addr, write_data and op are latched.
REQ-015 On acceptance, go to WAIT when WAIT_CYCLES>0, otherwise go directly to RESPOND.
REQ-016 WAIT: a down-counter loaded with WAIT_CYCLES-1 decrements each cycle; at 0, go to RESPOND.
REQ-017 Acceptance-to-mem_ready latency is exactly WAIT_CYCLES+1 cycles.
REQ-018 RESPOND: mem_ready=1 for exactly one cycle, then IDLE; back-to-back requests are accepted in the following IDLE cycle.
REQ-019 Write commit: word[addr[ADDR_BITS+1:2]] <= latched data on the edge entering RESPOND.
REQ-020 Read: read_data is loaded on the edge entering RESPOND and holds until the next successful read.
REQ-021 Address bits above ADDR_BITS+1 are ignored, so addresses wrap modulo the array size.
REQ-022 Misaligned access (addr[1:0]!=0): no write and no read_data update; mem_err=1 with mem_ready.
REQ-023 mem_read and mem_write both high at acceptance: treated as an error; no access, mem_err=1 with mem_ready.
REQ-024 Strobe changes while busy are ignored; latched values govern the transaction.
REQ-025 Strobes high during the RESPOND cycle are not accepted; acceptance happens only in IDLE.

Reset
REQ-026 rst low forces, asynchronously: state=IDLE, counter=0, mem_ready=0, mem_err=0, busy=0, read_data=0.
REQ-027 Reset during WAIT aborts the transaction; no write is committed.
REQ-028 Array contents are not reset; they are initialised only by the bench through the sub-module.

Structure
REQ-029 FSM state encodings, the default WAIT_CYCLES and the 32-bit word width go in the shared constants header alongside the opcode and function codes.
REQ-030 One sub-module, mem_array, holds the storage: synchronous write, registered read, word-indexed, ADDR_BITS parameter.
REQ-031 Target size: 120-400 lines of RTL in total.

Verification
REQ-032 WAIT_CYCLES=2, write 0xDEADBEEF to addr 0x10, then read 0x10 -> mem_ready 3 cycles after each acceptance; read_data=0xDEADBEEF; mem_err=0.
REQ-033 WAIT_CYCLES=0, back-to-back reads of 0x0 then 0x4 -> mem_ready on the cycle after each acceptance; the second request is accepted the cycle after the first mem_ready.
REQ-034 Write 0x12345678 to addr 0x402 -> mem_err=1 with mem_ready; the word at 0x400 is unchanged on readback; read_data unchanged.
REQ-035 mem_read and mem_write both high at addr 0x20 -> mem_err=1 with mem_ready; word 0x20 unchanged.
REQ-036 With ADDR_BITS=8, write 0xA5A5A5A5 to addr 0x400, read addr 0x0 -> read_data=0xA5A5A5A5 (wrap-around).
REQ-037 Assert rst low one cycle into WAIT of a write of 0x55 to 0x8 -> outputs return to reset values immediately; the word at 0x8 keeps its prior value.
